// File: rtl/disp_share_arb.sv
// Round-robin display-sharing arbiter for hex0 and the LEDs, with a minimum dwell per grant.
// Optional build macro DISP_SHARE_ARB_PREEMPT_EN lets requester 0 preempt a dwell.
module disp_share_arb #(
  parameter  int NUM_REQ      = 4,
  parameter  int HEX_W        = 8,
  parameter  int LED_W        = 10,
  parameter  int DWELL_CYCLES = 50000000,
  localparam int OWN_W        = $clog2(NUM_REQ),
  localparam int CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*HEX_W-1:0] req_hex,
  input  logic [NUM_REQ*LED_W-1:0] req_led,
  output logic [HEX_W-1:0]         hex_out,
  output logic [LED_W-1:0]         led_out,
  output logic [OWN_W-1:0]         owner,
  output logic                     owner_valid
);

  typedef enum logic {ST_ARB, ST_DWELL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OWN_W-1:0]   last_q, last_d;
  logic [HEX_W-1:0]   hex_q, hex_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic               owner_valid_q, owner_valid_d;

  logic               gnt_found;
  logic [OWN_W-1:0]   gnt_idx;
  logic [OWN_W-1:0]   cand;
  logic               preempt;
  logic [OWN_W-1:0]   load_sel;
  logic [HEX_W-1:0]   hex_sel;
  logic [LED_W-1:0]   led_sel;
  logic [NUM_REQ-1:0] ready_c;

  // Search starts just past the last winner so every requester gets its turn.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OWN_W'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

`ifdef DISP_SHARE_ARB_PREEMPT_EN
  assign preempt = (state_q == ST_DWELL) && (owner_q != '0) && req_valid[0];
`else
  assign preempt = 1'b0;
`endif

  assign load_sel = preempt ? '0 : gnt_idx;

  always_comb begin
    hex_sel = '1;
    led_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OWN_W'(i) == load_sel) begin
        hex_sel = req_hex[i*HEX_W +: HEX_W];
        led_sel = req_led[i*LED_W +: LED_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
    hex_d         = hex_q;
    led_d         = led_q;
    owner_d       = owner_q;
    owner_valid_d = owner_valid_q;
    ready_c       = '0;
    case (state_q)
      ST_ARB: begin
        if (gnt_found) begin
          ready_c[gnt_idx] = 1'b1;
          hex_d            = hex_sel;
          led_d            = led_sel;
          owner_d          = gnt_idx;
          owner_valid_d    = 1'b1;
          last_d           = gnt_idx;
          cnt_d            = CNT_W'(DWELL_CYCLES - 1);
          state_d          = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (preempt) begin
          ready_c[0]    = 1'b1;
          hex_d         = hex_sel;
          led_d         = led_sel;
          owner_d       = '0;
          owner_valid_d = 1'b1;
          last_d        = '0;
          cnt_d         = CNT_W'(DWELL_CYCLES - 1);
        end else if (cnt_q == '0) begin
          state_d = ST_ARB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q       <= ST_ARB;
      cnt_q         <= '0;
      last_q        <= OWN_W'(NUM_REQ - 1);
      hex_q         <= '1;
      led_q         <= '0;
      owner_q       <= '0;
      owner_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_q        <= last_d;
      hex_q         <= hex_d;
      led_q         <= led_d;
      owner_q       <= owner_d;
      owner_valid_q <= owner_valid_d;
    end
  end

  // Ready is masked during reset so no requester sees an accept that never lands.
  assign req_ready   = ready_c & {NUM_REQ{reset_reset_n}};
  assign hex_out     = hex_q;
  assign led_out     = led_q;
  assign owner       = owner_q;
  assign owner_valid = owner_valid_q;

endmodule

// File: tb/tb_disp_share_arb.sv
// Directed bench for disp_share_arb: cycle table with NUM_REQ=4, DWELL_CYCLES=4,
// plus hand sequences for preemption and a DWELL_CYCLES=1 instance.
module tb_disp_share_arb;

  logic        clk;
  logic        rst_n;
  logic [3:0]  valid;
  logic [3:0]  req_ready;
  logic [31:0] hex;
  logic [39:0] led;
  logic [7:0]  hex_out;
  logic [9:0]  led_out;
  logic [1:0]  owner;
  logic        owner_valid;

  logic [1:0]  v1;
  logic [1:0]  rdy1;
  logic [15:0] hx1;
  logic [19:0] ld1;
  logic [7:0]  hex_out1;
  logic [9:0]  led_out1;
  logic [0:0]  owner1;
  logic        ov1;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] HX = 32'h11_C0_22_33;
  localparam logic [39:0] LD = {10'h3C3, 10'h155, 10'h0F0, 10'h00F};

  disp_share_arb #(.NUM_REQ(4), .HEX_W(8), .LED_W(10), .DWELL_CYCLES(4)) u_dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .req_valid(valid), .req_ready(req_ready),
    .req_hex(hex), .req_led(led), .hex_out(hex_out), .led_out(led_out),
    .owner(owner), .owner_valid(owner_valid)
  );

  disp_share_arb #(.NUM_REQ(2), .HEX_W(8), .LED_W(10), .DWELL_CYCLES(1)) u_d1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .req_valid(v1), .req_ready(rdy1),
    .req_hex(hx1), .req_led(ld1), .hex_out(hex_out1), .led_out(led_out1),
    .owner(owner1), .owner_valid(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] hex;
    logic [39:0] led;
    logic [3:0]  ready;
    logic [7:0]  ehex;
    logic [9:0]  eled;
    logic [1:0]  own;
    logic        ov;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [3:0] v, input logic [31:0] h,
                              input logic [3:0] rd, input logic [7:0] eh, input logic [9:0] el,
                              input logic [1:0] ow, input logic o);
    vec_t e;
    e.rst_n = r; e.valid = v; e.hex = h; e.led = LD;
    e.ready = rd; e.ehex = eh; e.eled = el; e.own = ow; e.ov = o;
    tbl.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  int got;
  int exp_wait;
  logic [1:0] exp_rdy1 [5];

  initial begin
    // reset-held row, then single request from requester 2
    add(0, 4'b0100, HX, 4'b0000, 8'hFF, 10'h000, 0, 0);
    add(1, 4'b0100, HX, 4'b0100, 8'hFF, 10'h000, 0, 0);
    add(1, 4'b0000, HX, 4'b0000, 8'hC0, 10'h155, 2, 1);
    for (int i = 0; i < 3; i++) add(1, 4'b1111, HX, 4'b0000, 8'hC0, 10'h155, 2, 1);
    // all four held: rotation 3,0,1,2 every 5 cycles
    add(1, 4'b1111, HX, 4'b1000, 8'hC0, 10'h155, 2, 1);
    for (int i = 0; i < 4; i++) add(1, 4'b1111, HX, 4'b0000, 8'h11, 10'h3C3, 3, 1);
    add(1, 4'b1111, HX, 4'b0001, 8'h11, 10'h3C3, 3, 1);
    for (int i = 0; i < 4; i++) add(1, 4'b1111, HX, 4'b0000, 8'h33, 10'h00F, 0, 1);
    add(1, 4'b1111, HX, 4'b0010, 8'h33, 10'h00F, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 4'b1111, HX, 4'b0000, 8'h22, 10'h0F0, 1, 1);
    add(1, 4'b1111, HX, 4'b0100, 8'h22, 10'h0F0, 1, 1);
    // valid[1] pulsed during dwell, then idle ARB holds, then valid[1] held
    add(1, 4'b0000, HX, 4'b0000, 8'hC0, 10'h155, 2, 1);
    add(1, 4'b0010, HX, 4'b0000, 8'hC0, 10'h155, 2, 1);
    for (int i = 0; i < 4; i++) add(1, 4'b0000, HX, 4'b0000, 8'hC0, 10'h155, 2, 1);
    add(1, 4'b0010, HX, 4'b0010, 8'hC0, 10'h155, 2, 1);
    add(1, 4'b0000, HX, 4'b0000, 8'h22, 10'h0F0, 1, 1);
    // only requester 1, data changing every cycle: reloads take the transfer-cycle data
    for (int c = 0; c < 15; c++) begin
      logic [7:0] d;
      logic [7:0] eh;
      d  = 8'h50 + 8'(c);
      eh = (c <= 3) ? 8'h22 : (c <= 8) ? 8'h53 : (c <= 13) ? 8'h58 : 8'h5D;
      add(1, 4'b0010, {HX[31:16], d, HX[7:0]},
          (c == 3 || c == 8 || c == 13) ? 4'b0010 : 4'b0000, eh, 10'h0F0, 1, 1);
    end
    // requester 3 wins, then reset at counter 2; requester 0 wins first afterwards
    for (int i = 0; i < 3; i++) add(1, 4'b1000, HX, 4'b0000, 8'h5D, 10'h0F0, 1, 1);
    add(1, 4'b1000, HX, 4'b1000, 8'h5D, 10'h0F0, 1, 1);
    add(1, 4'b1000, HX, 4'b0000, 8'h11, 10'h3C3, 3, 1);
    add(0, 4'b1000, HX, 4'b0000, 8'h11, 10'h3C3, 3, 1);
    add(1, 4'b1001, HX, 4'b0001, 8'hFF, 10'h000, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 4'b0000, HX, 4'b0000, 8'h33, 10'h00F, 0, 1);
    add(1, 4'b0100, HX, 4'b0100, 8'h33, 10'h00F, 0, 1);

    rst_n = 1'b0; valid = '0; hex = HX; led = LD;
    v1 = '0; hx1 = 16'hA1B2; ld1 = {10'h2AA, 10'h111};
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; valid = tbl[i].valid; hex = tbl[i].hex; led = tbl[i].led;
      #1;
      chk($sformatf("row%0d ready", i), 64'(req_ready), 64'(tbl[i].ready));
      chk($sformatf("row%0d hex", i), 64'(hex_out), 64'(tbl[i].ehex));
      chk($sformatf("row%0d led", i), 64'(led_out), 64'(tbl[i].eled));
      chk($sformatf("row%0d owner", i), 64'(owner), 64'(tbl[i].own));
      chk($sformatf("row%0d owner_valid", i), 64'(owner_valid), 64'(tbl[i].ov));
    end

    // requester 0 urgent request while requester 2 is in its first dwell cycle
    @(negedge clk);
    valid = 4'b0001; hex = {HX[31:8], 8'h86};
    #1;
    chk("pre owner", 64'(owner), 64'd2);
    chk("pre hex", 64'(hex_out), 64'hC0);
`ifdef DISP_SHARE_ARB_PREEMPT_EN
    exp_wait = 0;
`else
    exp_wait = 4;
`endif
    got = -1;
    for (int k = 0; k < 8 && got < 0; k++) begin
      if (k > 0) #1;
      if (req_ready === 4'b0001) got = k;
      @(posedge clk); @(negedge clk);
    end
    chk("urgent grant wait", 64'(got), 64'(exp_wait));
    #1;
    chk("urgent hex", 64'(hex_out), 64'h86);
    chk("urgent owner", 64'(owner), 64'd0);
    valid = 4'b0010;
    got = -1;
    for (int k = 0; k < 8 && got < 0; k++) begin
      #1;
      if (req_ready === 4'b0010) got = k;
      @(posedge clk); @(negedge clk);
    end
    chk("post-urgent dwell", 64'(got), 64'd4);
    #1;
    chk("post-urgent owner", 64'(owner), 64'd1);
    chk("post-urgent hex", 64'(hex_out), 64'h22);
    valid = '0;

    // DWELL_CYCLES=1: two requesters alternate with a 2-cycle grant period
    exp_rdy1 = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    @(negedge clk);
    v1 = 2'b11;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("d1 ready k%0d", k), 64'(rdy1), 64'(exp_rdy1[k]));
      if (k == 1) begin
        chk("d1 owner0", 64'(owner1), 64'd0);
        chk("d1 hex0", 64'(hex_out1), 64'hB2);
        chk("d1 led0", 64'(led_out1), 64'h111);
      end
      if (k == 3) begin
        chk("d1 owner1", 64'(owner1), 64'd1);
        chk("d1 hex1", 64'(hex_out1), 64'hA1);
        chk("d1 led1", 64'(led_out1), 64'h2AA);
        chk("d1 ov", 64'(ov1), 64'd1);
      end
      @(posedge clk); @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
